keypad_scanner: RTL

Scans a 4x4 matrix keypad and turns its row/column lines into debounced hex key codes for the divider datapath. The block drives the column lines one at a time and reads the row lines. For each accepted press it delivers one `key_code` with a single-cycle `key_valid` strobe. It sits between the board pins (`col` out, `fil` in) and the A/B operand-capture FSM, and replaces the direct `fil` bypass used during debug.

---
 rtl/keypad_pkg.sv | 20 ++
 rtl/sync_2ff.sv | 26 ++
 rtl/keypad_scanner.sv | 128 ++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

  // Scanner control states.
  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } kp_state_t;

  // Hex code of each key, indexed [row][col].
  localparam logic [3:0] KEY_MAP [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}   // '*' -> E, '#' -> F
  };

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for pin inputs that idle high (pulled-up lines).
module sync_2ff #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // Two register stages; both reset to the idle (all-ones) level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= '1;
      q    <= '1;
    end else begin
      // NOTE: non-blocking assignments make both stages sample the old
      // values on the same edge; blocking ones would collapse them into one.
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives one column low at a time, debounces the
// row lines and emits one hex key code per accepted press.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 2700,
  parameter int DEBOUNCE_CYC = 270000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] fil,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int SLOT_W = $clog2(SCAN_DIV);
  localparam int DEB_W  = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYC - 1);

  kp_state_t         state, state_nxt;
  logic [3:0]        fil_s;
  logic [1:0]        c;
  logic [1:0]        row_r;
  logic [1:0]        row_idx;
  logic              one_low;
  logic              row_match;
  logic              all_high;
  logic              slot_last;
  logic              deb_last;
  logic [SLOT_W-1:0] slot_cnt;
  logic [DEB_W-1:0]  deb_cnt;
  logic              capture_row;
  logic              accept;
  logic              release_done;
  logic              advance_c;
  logic              slot_inc;
  logic              deb_inc;

  sync_2ff #(.W(4)) u_fil_sync (
    .clk (clk),
    .rst (rst),
    .d   (fil),
    .q   (fil_s)
  );

  // Row check: exactly one row low, and which one.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    one_low = 1'b0;
    row_idx = 2'd0;
    case (fil_s)
      4'b1110: begin one_low = 1'b1; row_idx = 2'd0; end
      4'b1101: begin one_low = 1'b1; row_idx = 2'd1; end
      4'b1011: begin one_low = 1'b1; row_idx = 2'd2; end
      4'b0111: begin one_low = 1'b1; row_idx = 2'd3; end
      default: ;
    endcase
  end

  assign row_match = (fil_s == ~(4'b0001 << row_r));
  assign all_high  = (fil_s == 4'hF);
  assign slot_last = (slot_cnt == SLOT_LAST);
  assign deb_last  = (deb_cnt == DEB_LAST);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= SCAN;
    else      state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      SCAN:     if (slot_last && one_low) state_nxt = DEBOUNCE;
      DEBOUNCE: if (!row_match)           state_nxt = SCAN;
                else if (deb_last)        state_nxt = HELD;
      HELD:     if (all_high)             state_nxt = RELEASE;
      RELEASE:  if (!all_high)            state_nxt = HELD;
                else if (deb_last)        state_nxt = SCAN;
      default:                            state_nxt = SCAN;
    endcase
  end

  // Control strobes and column drive decoded from state and inputs.
  always_comb begin
    capture_row  = (state == SCAN) && slot_last && one_low;
    accept       = (state == DEBOUNCE) && row_match && deb_last;
    release_done = (state == RELEASE) && all_high && deb_last;
    advance_c    = ((state == SCAN) && slot_last && !one_low) ||
                   ((state == DEBOUNCE) && !row_match) ||
                   release_done;
    slot_inc     = (state == SCAN) && !slot_last;
    deb_inc      = (((state == DEBOUNCE) && row_match) ||
                    ((state == RELEASE) && all_high)) && !deb_last;
    col          = ~(4'b0001 << c);
  end

  // Counters, column index, captured row and key outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_cnt  <= '0;
      deb_cnt   <= '0;
      c         <= 2'd0;
      row_r     <= 2'd0;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      slot_cnt  <= slot_inc ? slot_cnt + SLOT_W'(1) : '0;
      deb_cnt   <= deb_inc  ? deb_cnt + DEB_W'(1)   : '0;
      key_valid <= accept;
      if (advance_c)   c     <= c + 2'd1;
      if (capture_row) row_r <= row_idx;
      if (accept) begin
        key_code <= KEY_MAP[row_r][c];
        key_held <= 1'b1;
      end else if (release_done) begin
        key_held <= 1'b0;
      end
    end
  end

endmodule
